game_status_ctrl: RTL and testbench
===================================

# game_status_ctrl

Parametrised game-status controller for the Pac-Man design: checks the pacman against `NUM_GHOSTS` ghosts once per frame and tracks lives, score and game state. It replaces the single-ghost crash check and the sticky game-over latch. Game-over now follows a lives count and an invulnerability window, and a restart path brings the game back from game over. It sits between the movement blocks (pacman and ghost positions) and the display and seven-segment blocks (`state`, `score`, `over`).

## Interface
Parameters:
- `NUM_GHOSTS`, 4: number of ghosts checked; legal range 1..8.
- `COORD_W`, 10: width of every x/y coordinate.
- `HIT_RADIUS`, 16: collision threshold in pixels; a hit needs |dx| < HIT_RADIUS and |dy| < HIT_RADIUS.
- `LIVES`, 3: lives at game start; legal range 1..7.
- `HIT_FRAMES`, 60: frames spent frozen in HIT.
- `INVULN_FRAMES`, 120: frames of invulnerability after a respawn.
- `PELLET_PTS`, 10: points added per pellet.
- `SCORE_W`, 16: score width.

Ports:
- `clk` in 1: system clock.
- `clrn` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `start` in 1: level-sensitive start/restart request.
- `pellet_eaten` in 1: one-cycle pulse per pellet eaten.
- `pac_x`, `pac_y` in COORD_W each: pacman position.
- `ghost_x`, `ghost_y` in NUM_GHOSTS*COORD_W each: packed ghost positions; ghost i occupies bits [i*COORD_W +: COORD_W].
- `state` out 2: 0 IDLE, 1 PLAY, 2 HIT, 3 OVER.
- `lives` out 3: lives remaining.
- `score` out SCORE_W: score, binary.
- `invuln` out 1: high while the invulnerability counter is non-zero.
- `hit_vec` out NUM_GHOSTS: registered per-ghost collision flags.
- `hit_pulse` out 1: one-cycle pulse on each accepted hit.
- `respawn` out 1: one-cycle pulse when HIT ends.
- `over` out 1: equals (state == OVER).

## Operation
- Reset values: state IDLE, lives 0, score 0, invuln 0, hit_vec 0, hit_pulse 0, respawn 0, over 0, all counters 0.
- **Collision stage:**
  - On a cycle with `frame_tick`, compute |dx| and |dy| per ghost in COORD_W+1-bit signed arithmetic.
  - Register the results into `hit_vec` and set `eval_pending`.
  - `hit_vec` is otherwise held; `eval_pending` clears the next cycle.
- **IDLE:**
  - `start` = 1 leads to PLAY, with lives = LIVES, score = 0, invuln = 0.
- **PLAY:**
  - `pellet_eaten` adds PELLET_PTS to score, saturating at 2^SCORE_W − 1.
  - On `frame_tick`, the invulnerability counter decrements if non-zero.
  - On `eval_pending`, a hit is accepted when |hit_vec| = 1 and the counter is 0. Then:
    - `hit_pulse` is asserted and lives is decremented.
    - If the new lives value is 0, go to OVER; otherwise go to HIT and load the frame counter with HIT_FRAMES.
  - A hit with the counter non-zero is ignored; `hit_vec` still shows it.
  - Several ghosts overlapping in the same frame cost exactly one life.
- **HIT:**
  - Score is frozen and `pellet_eaten` is ignored.
  - The frame counter decrements on `frame_tick`.
  - When a `frame_tick` finds the counter at 1: `respawn` pulses, the invulnerability counter loads INVULN_FRAMES, and the state returns to PLAY.
  - Collisions are ignored.
- **OVER:**
  - Sticky: score and lives are held and `over` = 1.
  - `start` = 1 leads to PLAY, with lives = LIVES, score = 0, invuln = 0.
- **Simultaneous events:**
  - Pellet and accepted hit in the same cycle: both apply (score increments, life is lost).
  - `frame_tick` and `eval_pending` never coincide except when ticks come on consecutive cycles. In that case the counter decrement and hit evaluation both use the pre-decrement counter value.
- **Reset mid-game:** `clrn` low forces all reset values immediately, regardless of state.

## Timing
- Collision latency:
  - `frame_tick` in cycle t samples the positions.
  - `hit_vec` is valid in t+1, and the hit decision is taken at the end of t+1.
  - `hit_pulse`, the new `lives` and the new `state` are visible in t+2.
- Pellet latency: `pellet_eaten` in cycle t is reflected in `score` in t+1.
- HIT duration: exactly HIT_FRAMES `frame_tick`s. `respawn` is high in the cycle after the last tick, together with state = PLAY and `invuln` = 1.
- Start: `start` sampled in cycle t gives state PLAY in t+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset/start:** assert `clrn` = 0 mid-PLAY → all outputs 0, state 0. Release, then `start` = 1 for one cycle → state 1, lives 3, score 0.
- **Scoring and saturation:** 5 `pellet_eaten` pulses → score 50. Preload score to 65530 and add one pellet → score 65535; one more → score 65535.
- **Single hit:**
  - Setup: pac (100,100), ghost 2 at (110,90), others far away.
  - `frame_tick` → hit_vec = 4'b0100, hit_pulse in cycle t+2, lives 2, state 2.
  - After 60 ticks: respawn = 1, invuln = 1, state 1.
- **Boundary radius:**
  - Ghost at (116,100) against pac (100,100): no hit.
  - Ghost at (115,100): hit.
  - Ghost at (84,100): no hit.
  - Ghost at (85,100): hit.
- **Invulnerability and multi-ghost:**
  - Right after respawn, overlap all 4 ghosts → no hit_pulse, lives unchanged.
  - After 120 ticks, overlap all 4 again → exactly one life lost.
- **Game over/restart:**
  - Lose 3 lives → state 3, over = 1.
  - Further collisions and pellets → lives, score and state unchanged.
  - `start` → state 1, lives 3, score 0.

Source files
------------

// File: rtl/game_status_ctrl.sv
// game_status_ctrl
//   Once-per-frame pacman/ghost collision check plus the game state machine
//   (IDLE/PLAY/HIT/OVER). Tracks lives, a saturating score, the post-respawn
//   invulnerability window and the frozen HIT interval.
//
// Ports
//   clk_i, clrn_i            clock, async active-low reset
//   frame_tick_i             one-cycle pulse per video frame
//   start_i                  level start/restart request (IDLE, OVER)
//   pellet_eaten_i           one-cycle pulse per pellet
//   pac_x_i, pac_y_i         pacman position
//   ghost_x_i, ghost_y_i     packed ghost positions, ghost g at [g*COORD_W +: COORD_W]
//   state_o                  0 IDLE, 1 PLAY, 2 HIT, 3 OVER
//   lives_o, score_o         lives remaining, binary score
//   invuln_o                 invulnerability counter non-zero
//   hit_vec_o                registered per-ghost collision flags
//   hit_pulse_o, respawn_o   one-cycle event pulses
//   over_o                   state_o == OVER

// Per-ghost proximity test: |dx| < R and |dy| < R, computed one bit wider
// than the coordinates so the difference never wraps.
module ghost_hit_lane #(
  parameter int COORD_W    = 10,
  parameter int HIT_RADIUS = 16
) (
  input  logic [COORD_W-1:0] pac_x_i,
  input  logic [COORD_W-1:0] pac_y_i,
  input  logic [COORD_W-1:0] gh_x_i,
  input  logic [COORD_W-1:0] gh_y_i,
  output logic               hit_o
);
  localparam logic [COORD_W:0] ONE = (COORD_W+1)'(1);
  localparam logic [COORD_W:0] RAD = (COORD_W+1)'(HIT_RADIUS);

  logic [COORD_W:0] dx, dy, adx, ady;

  assign dx  = {1'b0, pac_x_i} - {1'b0, gh_x_i};
  assign dy  = {1'b0, pac_y_i} - {1'b0, gh_y_i};
  assign adx = dx[COORD_W] ? (~dx + ONE) : dx;
  assign ady = dy[COORD_W] ? (~dy + ONE) : dy;
  assign hit_o = (adx < RAD) && (ady < RAD);
endmodule

module game_status_ctrl #(
  parameter int NUM_GHOSTS    = 4,
  parameter int COORD_W       = 10,
  parameter int HIT_RADIUS    = 16,
  parameter int LIVES         = 3,
  parameter int HIT_FRAMES    = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int PELLET_PTS    = 10,
  parameter int SCORE_W       = 16
) (
  input  logic                          clk_i,
  input  logic                          clrn_i,
  input  logic                          frame_tick_i,
  input  logic                          start_i,
  input  logic                          pellet_eaten_i,
  input  logic [COORD_W-1:0]            pac_x_i,
  input  logic [COORD_W-1:0]            pac_y_i,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x_i,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y_i,
  output logic [1:0]                    state_o,
  output logic [2:0]                    lives_o,
  output logic [SCORE_W-1:0]            score_o,
  output logic                          invuln_o,
  output logic [NUM_GHOSTS-1:0]         hit_vec_o,
  output logic                          hit_pulse_o,
  output logic                          respawn_o,
  output logic                          over_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;

  localparam int HCW = $clog2(HIT_FRAMES + 1);
  localparam int ICW = $clog2(INVULN_FRAMES + 1);
  localparam logic [HCW-1:0]     HIT_LD  = HCW'(HIT_FRAMES);
  localparam logic [HCW-1:0]     HIT_ONE = HCW'(1);
  localparam logic [ICW-1:0]     INV_LD  = ICW'(INVULN_FRAMES);
  localparam logic [ICW-1:0]     INV_ONE = ICW'(1);
  localparam logic [2:0]         LIVES_LD = 3'(LIVES);
  localparam logic [SCORE_W:0]   PTS     = (SCORE_W+1)'(PELLET_PTS);

  state_t                 state_q, state_d;
  logic [2:0]             lives_q, lives_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [ICW-1:0]         inv_q, inv_d;
  logic [HCW-1:0]         hcnt_q, hcnt_d;
  logic [NUM_GHOSTS-1:0]  hit_vec_q, hit_vec_d, hit_now;
  logic                   eval_q, eval_d;
  logic                   hit_pulse_q, hit_pulse_d;
  logic                   respawn_q, respawn_d;
  logic                   accept, restart;
  logic [SCORE_W:0]       score_sum;

  // Collision stage: one lane per ghost
  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_lane
    ghost_hit_lane #(.COORD_W(COORD_W), .HIT_RADIUS(HIT_RADIUS)) u_lane (
      .pac_x_i (pac_x_i),
      .pac_y_i (pac_y_i),
      .gh_x_i  (ghost_x_i[g*COORD_W +: COORD_W]),
      .gh_y_i  (ghost_y_i[g*COORD_W +: COORD_W]),
      .hit_o   (hit_now[g])
    );
  end

  // Any number of overlapping ghosts is a single hit. The counter value used
  // here is pre-decrement even when a tick lands in the same cycle.
  assign accept  = (state_q == PLAY) && eval_q && (|hit_vec_q) && (inv_q == '0);
  assign restart = ((state_q == IDLE) || (state_q == OVER)) && start_i;
  assign score_sum = {1'b0, score_q} + PTS;

  // State register (plus datapath registers)
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      state_q     <= IDLE;
      lives_q     <= '0;
      score_q     <= '0;
      inv_q       <= '0;
      hcnt_q      <= '0;
      hit_vec_q   <= '0;
      eval_q      <= 1'b0;
      hit_pulse_q <= 1'b0;
      respawn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      inv_q       <= inv_d;
      hcnt_q      <= hcnt_d;
      hit_vec_q   <= hit_vec_d;
      eval_q      <= eval_d;
      hit_pulse_q <= hit_pulse_d;
      respawn_q   <= respawn_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, OVER: if (start_i) state_d = PLAY;
      PLAY:       if (accept) state_d = (lives_q == 3'd1) ? OVER : HIT;
      HIT:        if (frame_tick_i && hcnt_q == HIT_ONE) state_d = PLAY;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    lives_d     = lives_q;
    score_d     = score_q;
    inv_d       = inv_q;
    hcnt_d      = hcnt_q;
    hit_vec_d   = frame_tick_i ? hit_now : hit_vec_q;
    eval_d      = frame_tick_i;
    hit_pulse_d = 1'b0;
    respawn_d   = 1'b0;

    if (restart) begin
      lives_d = LIVES_LD;
      score_d = '0;
      inv_d   = '0;
      hcnt_d  = '0;
    end else if (state_q == PLAY) begin
      if (pellet_eaten_i)
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      if (frame_tick_i && inv_q != '0)
        inv_d = inv_q - INV_ONE;
      if (accept) begin
        hit_pulse_d = 1'b1;
        lives_d     = lives_q - 3'd1;
        if (lives_q != 3'd1) hcnt_d = HIT_LD;
      end
    end else if (state_q == HIT && frame_tick_i) begin
      if (hcnt_q == HIT_ONE) begin
        respawn_d = 1'b1;
        inv_d     = INV_LD;
        hcnt_d    = '0;
      end else begin
        hcnt_d = hcnt_q - HIT_ONE;
      end
    end
  end

  assign state_o     = state_q;
  assign lives_o     = lives_q;
  assign score_o     = score_q;
  assign invuln_o    = (inv_q != '0);
  assign hit_vec_o   = hit_vec_q;
  assign hit_pulse_o = hit_pulse_q;
  assign respawn_o   = respawn_q;
  assign over_o      = (state_q == OVER);
endmodule

// File: tb/tb_game_status_ctrl.sv
module tb_game_status_ctrl;
  localparam int NG = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          frame_tick = 1'b0, start = 1'b0, pellet = 1'b0;
  logic [CW-1:0] pac_x = 10'd100, pac_y = 10'd100;
  logic [NG*CW-1:0] ghost_x = '1, ghost_y = '1;
  logic [1:0]    state;
  logic [2:0]    lives;
  logic [15:0]   score;
  logic          invuln, hit_pulse, respawn, over;
  logic [NG-1:0] hit_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_status_ctrl dut (
    .clk_i(clk), .clrn_i(clrn), .frame_tick_i(frame_tick), .start_i(start),
    .pellet_eaten_i(pellet), .pac_x_i(pac_x), .pac_y_i(pac_y),
    .ghost_x_i(ghost_x), .ghost_y_i(ghost_y), .state_o(state), .lives_o(lives),
    .score_o(score), .invuln_o(invuln), .hit_vec_o(hit_vec),
    .hit_pulse_o(hit_pulse), .respawn_o(respawn), .over_o(over)
  );

  task automatic set_ghost(input int i, input int x, input int y);
    ghost_x[i*CW +: CW] = CW'(x);
    ghost_y[i*CW +: CW] = CW'(y);
  endtask

  task automatic ghosts_far();
    for (int i = 0; i < NG; i++) set_ghost(i, 600, 600);
  endtask

  task automatic ghosts_on_pac();
    for (int i = 0; i < NG; i++) set_ghost(i, 100, 100);
  endtask

  // Tick sampled at one posedge; returns at the negedge after it (hit_vec valid).
  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pellets(input int n);
    @(negedge clk); pellet = 1'b1;
    repeat (n) @(negedge clk);
    pellet = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({state, lives, score, invuln, hit_vec, hit_pulse, respawn, over} !== '0) begin
      errors++; $display("FAIL reset_state got st=%0d lv=%0d sc=%0d iv=%0b hv=%b hp=%0b rs=%0b ov=%0b",
                         state, lives, score, invuln, hit_vec, hit_pulse, respawn, over);
    end
    clrn = 1'b1;
    do_start();
    checks++; if (state !== 2'd1 || lives !== 3'd3 || score !== 16'd0) begin
      errors++; $display("FAIL start got st=%0d lv=%0d sc=%0d want 1 3 0", state, lives, score);
    end
    pellets(2);
    checks++; if (score !== 16'd20) begin
      errors++; $display("FAIL pre_reset_score got %0d want 20", score);
    end
    // asynchronous reset while playing
    @(negedge clk); clrn = 1'b0; #1;
    checks++; if ({state, lives, score, invuln, hit_vec, hit_pulse, respawn, over} !== '0) begin
      errors++; $display("FAIL midgame_reset got st=%0d lv=%0d sc=%0d", state, lives, score);
    end
    @(negedge clk); clrn = 1'b1;
  endtask

  // Runs in IDLE: hit_vec updates but the game state must not move.
  task automatic test_boundary();
    logic [NG-1:0] exp_hv [5] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    int gx [5] = '{116, 115, 84, 85, 100};
    int gy [5] = '{100, 100, 100, 100, 116};
    ghosts_far();
    for (int k = 0; k < 5; k++) begin
      set_ghost(0, gx[k], gy[k]);
      tick();
      checks++; if (hit_vec !== exp_hv[k]) begin
        errors++; $display("FAIL boundary(%0d,%0d) got %b want %b", gx[k], gy[k], hit_vec, exp_hv[k]);
      end
    end
    @(negedge clk);
    checks++; if (state !== 2'd0 || hit_pulse !== 1'b0) begin
      errors++; $display("FAIL boundary_idle got st=%0d hp=%0b want 0 0", state, hit_pulse);
    end
  endtask

  task automatic test_single_hit();
    ghosts_far();
    do_start();
    pellets(3);
    set_ghost(2, 110, 90);
    tick();
    checks++; if (hit_vec !== 4'b0100 || hit_pulse !== 1'b0) begin
      errors++; $display("FAIL single_hitvec got %b hp=%0b want 0100 0", hit_vec, hit_pulse);
    end
    @(negedge clk);
    checks++; if (hit_pulse !== 1'b1 || lives !== 3'd2 || state !== 2'd2) begin
      errors++; $display("FAIL single_hit got hp=%0b lv=%0d st=%0d want 1 2 2", hit_pulse, lives, state);
    end
    pellets(2);
    checks++; if (score !== 16'd30 || hit_pulse !== 1'b0) begin
      errors++; $display("FAIL hit_frozen got sc=%0d hp=%0b want 30 0", score, hit_pulse);
    end
    run_ticks(59);
    checks++; if (state !== 2'd2 || respawn !== 1'b0) begin
      errors++; $display("FAIL hit_len59 got st=%0d rs=%0b want 2 0", state, respawn);
    end
    tick();
    checks++; if (respawn !== 1'b1 || invuln !== 1'b1 || state !== 2'd1) begin
      errors++; $display("FAIL respawn got rs=%0b iv=%0b st=%0d want 1 1 1", respawn, invuln, state);
    end
  endtask

  task automatic test_invuln_multi();
    ghosts_on_pac();
    tick();
    checks++; if (hit_vec !== 4'b1111) begin
      errors++; $display("FAIL multi_hitvec got %b want 1111", hit_vec);
    end
    @(negedge clk);
    checks++; if (hit_pulse !== 1'b0 || lives !== 3'd2 || state !== 2'd1) begin
      errors++; $display("FAIL invuln_ignore got hp=%0b lv=%0d st=%0d want 0 2 1", hit_pulse, lives, state);
    end
    ghosts_far();
    run_ticks(118);
    checks++; if (invuln !== 1'b1) begin
      errors++; $display("FAIL invuln_119 got %0b want 1", invuln);
    end
    tick();
    checks++; if (invuln !== 1'b0) begin
      errors++; $display("FAIL invuln_120 got %0b want 0", invuln);
    end
    ghosts_on_pac();
    tick();
    @(negedge clk);
    checks++; if (hit_pulse !== 1'b1 || lives !== 3'd1 || state !== 2'd2) begin
      errors++; $display("FAIL multi_hit got hp=%0b lv=%0d st=%0d want 1 1 2", hit_pulse, lives, state);
    end
    @(negedge clk);
    checks++; if (hit_pulse !== 1'b0 || lives !== 3'd1) begin
      errors++; $display("FAIL one_life got hp=%0b lv=%0d want 0 1", hit_pulse, lives);
    end
  endtask

  task automatic test_game_over();
    ghosts_far();
    run_ticks(60 + 120);
    checks++; if (state !== 2'd1 || invuln !== 1'b0) begin
      errors++; $display("FAIL pre_over got st=%0d iv=%0b want 1 0", state, invuln);
    end
    ghosts_on_pac();
    tick();
    @(negedge clk);
    checks++; if (state !== 2'd3 || over !== 1'b1 || lives !== 3'd0 || hit_pulse !== 1'b1) begin
      errors++; $display("FAIL game_over got st=%0d ov=%0b lv=%0d hp=%0b want 3 1 0 1", state, over, lives, hit_pulse);
    end
    pellets(3);
    run_ticks(3);
    @(negedge clk);
    checks++; if (state !== 2'd3 || lives !== 3'd0 || score !== 16'd30 || hit_pulse !== 1'b0) begin
      errors++; $display("FAIL over_sticky got st=%0d lv=%0d sc=%0d hp=%0b want 3 0 30 0", state, lives, score, hit_pulse);
    end
    ghosts_far();
    tick();
    do_start();
    checks++; if (state !== 2'd1 || lives !== 3'd3 || score !== 16'd0 || over !== 1'b0) begin
      errors++; $display("FAIL restart got st=%0d lv=%0d sc=%0d ov=%0b want 1 3 0 0", state, lives, score, over);
    end
  endtask

  task automatic test_scoring();
    pellets(5);
    checks++; if (score !== 16'd50) begin
      errors++; $display("FAIL score_50 got %0d want 50", score);
    end
    pellets(6548);
    checks++; if (score !== 16'd65530) begin
      errors++; $display("FAIL score_65530 got %0d want 65530", score);
    end
    pellets(1);
    checks++; if (score !== 16'd65535) begin
      errors++; $display("FAIL score_sat1 got %0d want 65535", score);
    end
    pellets(1);
    checks++; if (score !== 16'd65535) begin
      errors++; $display("FAIL score_sat2 got %0d want 65535", score);
    end
  endtask

  initial begin
    ghosts_far();
    test_reset();
    test_boundary();
    test_single_hit();
    test_invuln_multi();
    test_game_over();
    test_scoring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
